vector_join_collector: RTL and testbench
========================================

Name: vector_join_collector

Overview:
- Downstream neighbour of the vector fork stage; consumes the 4 lane results it produces each beat.
- Reassembles V-element result vectors from LANES parallel ALU lane outputs over V/LANES beats, using the fork's strided lane mapping.
- Presents the complete vector plus destination register address to the vector register file write-back port with a valid/ready handshake.

Parameters:
- N, 32, element width in bits.
- V, 20, elements per vector.
- LANES, 4, parallel lanes per beat.
- REG_AW, 3, vector register address width.
- Derived (localparam): BEATS = V/LANES = 5. V must be an exact multiple of LANES; elaboration error otherwise.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a new collection; latches dest_addr_i.
- dest_addr_i  in  REG_AW  destination vector register for this collection.
- lane_valid_i  in  1  Lane_Res_i carries one valid beat.
- Lane_Res_i  in  [LANES-1:0][N-1:0]  lane k result for the current beat.
- lane_ready_o  out  1  collector accepts a beat this cycle.
- beat_o  out  3  index of the next beat to be written (0..BEATS-1).
- busy_o  out  1  state is not IDLE.
- wb_valid_o  out  1  Result_VEC_o/wb_addr_o hold a complete vector.
- wb_ready_i  in  1  register file accepts write-back.
- wb_addr_o  out  REG_AW  latched destination address.
- Result_VEC_o  out  [V-1:0][N-1:0]  assembled vector buffer (registered).
- protocol_err_o  out  1  sticky protocol violation flag.

Behaviour:
- Reset (async, RST=1): state IDLE, beat 0, buffer all zero, wb_addr_o 0. All outputs are 0: lane_ready_o, wb_valid_o, busy_o, protocol_err_o.
- States: IDLE, COLLECT, DONE. lane_ready_o=1 only in COLLECT; wb_valid_o=1 only in DONE; busy_o=1 in COLLECT and DONE.
- IDLE, start_i=1: go to COLLECT, beat<=0, buffer<=0, wb_addr_o<=dest_addr_i.
- COLLECT, accepted beat (lane_valid_i=1): for k in 0..LANES-1, Result[k*BEATS+beat] <= Lane_Res_i[k]. Then beat<=beat+1.
- COLLECT, last beat: when an accepted beat has beat==BEATS-1, go to DONE and wrap beat to 0.
- COLLECT, lane_valid_i=0: stall; no change to beat or buffer. No timeout.
- DONE: buffer and wb_addr_o held stable. When wb_ready_i=1, the handshake completes on that edge and the next state is IDLE.
- DONE, handshake with start_i=1 in the same cycle: go directly to COLLECT, clearing the buffer and latching the new dest_addr_i (back-to-back collections).
- Minimum latency: start sampled at edge E0; beats sampled at edges E1..E5; wb_valid_o high after E5. With wb_ready_i tied high, wb_valid_o is high for exactly one cycle.
- Protocol errors set protocol_err_o (sticky, cleared only by RST):
  - lane_valid_i=1 in IDLE or DONE: beat dropped.
  - start_i=1 in COLLECT: ignored.
  - start_i=1 in DONE without wb_ready_i: ignored.
- No arithmetic on data: it is stored bit-exact. beat_o is a 3-bit counter and never exceeds BEATS-1.
- RST mid-collection or in DONE: immediate return to the reset state; the partial vector is discarded.

Test Plan:
- Basic collect: start_i with dest=3; 5 consecutive beats with lane k of beat b = 100*k+b; wb_ready_i=1 -> wb_valid_o high for one cycle after beat 5, wb_addr_o=3, Result[k*5+b]=100*k+b (e.g. Result[17]=302).
- Stalls: same data with lane_valid_i low for 2 cycles between beats 2 and 3 -> identical Result; wb_valid_o delayed by exactly 2 cycles; beat_o holds at 3 during the stall.
- Backpressure: wb_ready_i=0 for 4 cycles after DONE -> wb_valid_o stays high with Result/wb_addr_o stable and lane_ready_o=0; on wb_ready_i=1 -> IDLE next cycle.
- Back-to-back: start_i (dest=5) asserted in the handshake cycle of a dest=2 vector -> busy_o stays 1; new collection yields wb_addr_o=5; stale elements read 0 until written.
- Errors: lane_valid_i in IDLE, then start_i mid-COLLECT -> protocol_err_o=1 and stays 1; the in-flight vector is still completed correctly.
- Async reset: assert RST between edges after beat 2 -> all outputs 0 immediately; next start_i yields a clean full vector.

Source files
------------

// File: rtl/vector_join_collector_if.sv
// Lane-side and write-back-side signals of the vector join collector.
// slave = collector view, master = producer / register-file view.
interface vector_join_collector_if #(
  parameter int N      = 32,
  parameter int V      = 20,
  parameter int LANES  = 4,
  parameter int REG_AW = 3
);
  logic                        start_i;
  logic [REG_AW-1:0]           dest_addr_i;
  logic                        lane_valid_i;
  logic [LANES-1:0][N-1:0]     Lane_Res_i;
  logic                        lane_ready_o;
  logic [2:0]                  beat_o;
  logic                        busy_o;
  logic                        wb_valid_o;
  logic                        wb_ready_i;
  logic [REG_AW-1:0]           wb_addr_o;
  logic [V-1:0][N-1:0]         Result_VEC_o;
  logic                        protocol_err_o;

  modport slave (
    input  start_i, dest_addr_i, lane_valid_i, Lane_Res_i, wb_ready_i,
    output lane_ready_o, beat_o, busy_o, wb_valid_o, wb_addr_o,
           Result_VEC_o, protocol_err_o
  );

  modport master (
    output start_i, dest_addr_i, lane_valid_i, Lane_Res_i, wb_ready_i,
    input  lane_ready_o, beat_o, busy_o, wb_valid_o, wb_addr_o,
           Result_VEC_o, protocol_err_o
  );
endinterface

// File: rtl/vector_join_collector.sv
// Reassembles a V-element vector from LANES lane results per beat (strided
// mapping: lane k of beat b lands in element k*BEATS+b) and hands it to write-back.
module vector_join_collector #(
  parameter int N      = 32,
  parameter int V      = 20,
  parameter int LANES  = 4,
  parameter int REG_AW = 3
) (
  input logic                    CLK,
  input logic                    RST,
  vector_join_collector_if.slave bus
);
  localparam int BEATS = V / LANES;
  localparam int IW    = (V > 1) ? $clog2(V) : 1;

  if (V % LANES != 0) begin : g_bad_cfg
    $error("vector_join_collector: V must be an exact multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            beat_q, beat_d;
  logic [V-1:0][N-1:0]   buf_q, buf_d;
  logic [REG_AW-1:0]     addr_q, addr_d;
  logic                  err_q, err_d;
  logic                  lane_ready_q, lane_ready_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  busy_q, busy_d;
  logic [IW-1:0]         idx;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    err_d   = err_q;
    idx     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.lane_valid_i) err_d = 1'b1;
        if (bus.start_i) begin
          state_d = COLLECT;
          beat_d  = '0;
          buf_d   = '0;
          addr_d  = bus.dest_addr_i;
        end
      end
      COLLECT: begin
        if (bus.start_i) err_d = 1'b1;
        if (bus.lane_valid_i) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            idx        = IW'(k * BEATS) + IW'(beat_q);
            buf_d[idx] = bus.Lane_Res_i[k];
          end
          if (beat_q == 3'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      DONE: begin
        if (bus.lane_valid_i) err_d = 1'b1;
        if (bus.wb_ready_i) begin
          // A start in the handshake cycle chains straight into the next collection.
          if (bus.start_i) begin
            state_d = COLLECT;
            beat_d  = '0;
            buf_d   = '0;
            addr_d  = bus.dest_addr_i;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.start_i) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    lane_ready_d = (state_d == COLLECT);
    wb_valid_d   = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      buf_q        <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      lane_ready_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      buf_q        <= buf_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      lane_ready_q <= lane_ready_d;
      wb_valid_q   <= wb_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.lane_ready_o   = lane_ready_q;
  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.busy_o         = busy_q;
  assign bus.beat_o         = beat_q;
  assign bus.wb_addr_o      = addr_q;
  assign bus.Result_VEC_o   = buf_q;
  assign bus.protocol_err_o = err_q;
endmodule

// File: tb/tb_vector_join_collector.sv
// Directed sequence with random lane data, checked against an element-level
// reference vector built from the strided lane mapping.
module tb_vector_join_collector;
  localparam int N      = 32;
  localparam int V      = 20;
  localparam int LANES  = 4;
  localparam int REG_AW = 3;
  localparam int BEATS  = V / LANES;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  logic [V-1:0][N-1:0] exp_vec;
  logic [V-1:0][N-1:0] snap_vec;
  logic [REG_AW-1:0]   exp_addr;

  vector_join_collector_if #(.N(N), .V(V), .LANES(LANES), .REG_AW(REG_AW)) bus ();

  vector_join_collector #(.N(N), .V(V), .LANES(LANES), .REG_AW(REG_AW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [V-1:0][N-1:0] exp);
    n_checks++;
    assert (bus.Result_VEC_o === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.Result_VEC_o, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic err);
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_wbv"},  64'(bus.wb_valid_o), 64'd0);
    chk({tag, "_rdy"},  64'(bus.lane_ready_o), 64'd0);
    chk({tag, "_err"},  64'(bus.protocol_err_o), 64'(err));
  endtask

  task automatic start_col(input logic [REG_AW-1:0] dest);
    bus.start_i     = 1'b1;
    bus.dest_addr_i = dest;
    step();
    bus.start_i = 1'b0;
    exp_vec  = '0;
    exp_addr = dest;
    chk("start_busy", 64'(bus.busy_o), 64'd1);
    chk("start_rdy",  64'(bus.lane_ready_o), 64'd1);
    chk("start_beat", 64'(bus.beat_o), 64'd0);
  endtask

  // Presents one beat; pattern=1 uses 100*k+b, otherwise random data.
  task automatic send_beat(input int b, input bit pattern);
    bus.lane_valid_i = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      bus.Lane_Res_i[k]    = pattern ? N'(100 * k + b) : N'($urandom);
      exp_vec[k * BEATS + b] = bus.Lane_Res_i[k];
    end
    step();
    bus.lane_valid_i = 1'b0;
    chk("beat_idx", 64'(bus.beat_o), 64'((b + 1) % BEATS));
    chk("beat_wbv", 64'(bus.wb_valid_o), 64'(b == BEATS - 1));
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_wbv"},  64'(bus.wb_valid_o), 64'd1);
    chk({tag, "_rdy"},  64'(bus.lane_ready_o), 64'd0);
    chk({tag, "_addr"}, 64'(bus.wb_addr_o), 64'(exp_addr));
    chk_vec({tag, "_vec"}, exp_vec);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.dest_addr_i  = '0;
    bus.lane_valid_i = 1'b0;
    bus.Lane_Res_i   = '0;
    bus.wb_ready_i   = 1'b1;
    #12;
    chk_idle("reset", 1'b0);
    chk("reset_beat", 64'(bus.beat_o), 64'd0);
    chk("reset_addr", 64'(bus.wb_addr_o), 64'd0);
    chk_vec("reset_vec", '0);
    rst = 1'b0;

    // Basic collect, wb_ready held high: one-cycle wb_valid.
    start_col(3'd3);
    for (int b = 0; b < BEATS; b++) send_beat(b, 1'b1);
    chk_done("basic");
    chk("basic_e17", 64'(bus.Result_VEC_o[17]), 64'd302);
    step();
    chk_idle("basic_after", 1'b0);

    // Stalls between beats 2 and 3.
    start_col(3'($urandom_range(0, 7)));
    for (int b = 0; b < 3; b++) send_beat(b, 1'b0);
    for (int s = 0; s < 2; s++) begin
      step();
      chk("stall_beat", 64'(bus.beat_o), 64'd3);
      chk("stall_wbv",  64'(bus.wb_valid_o), 64'd0);
      chk_vec("stall_vec", exp_vec);
    end
    for (int b = 3; b < BEATS; b++) send_beat(b, 1'b0);
    chk_done("stall");
    step();
    chk_idle("stall_after", 1'b0);

    // Backpressure: DONE held four cycles.
    bus.wb_ready_i = 1'b0;
    start_col(3'($urandom_range(0, 7)));
    for (int b = 0; b < BEATS; b++) send_beat(b, 1'b0);
    for (int s = 0; s < 4; s++) begin
      chk_done("bp");
      step();
    end
    chk_done("bp_last");
    bus.wb_ready_i = 1'b1;
    step();
    chk_idle("bp_after", 1'b0);

    // Back-to-back: start dest=5 in the handshake cycle of a dest=2 vector.
    bus.wb_ready_i = 1'b0;
    start_col(3'd2);
    for (int b = 0; b < BEATS; b++) send_beat(b, 1'b0);
    chk_done("b2b_first");
    bus.wb_ready_i  = 1'b1;
    bus.start_i     = 1'b1;
    bus.dest_addr_i = 3'd5;
    step();
    bus.start_i = 1'b0;
    exp_vec  = '0;
    exp_addr = 3'd5;
    chk("b2b_busy", 64'(bus.busy_o), 64'd1);
    chk("b2b_rdy",  64'(bus.lane_ready_o), 64'd1);
    chk("b2b_addr", 64'(bus.wb_addr_o), 64'd5);
    chk_vec("b2b_clear", exp_vec);
    send_beat(0, 1'b0);
    chk_vec("b2b_partial", exp_vec);
    for (int b = 1; b < BEATS; b++) send_beat(b, 1'b0);
    chk_done("b2b_second");
    chk("b2b_err", 64'(bus.protocol_err_o), 64'd0);
    step();
    chk_idle("b2b_after", 1'b0);

    // Protocol errors: lane_valid in IDLE, then start mid-collection.
    bus.lane_valid_i = 1'b1;
    step();
    bus.lane_valid_i = 1'b0;
    chk_idle("err_idle", 1'b1);
    start_col(3'd6);
    for (int b = 0; b < 2; b++) send_beat(b, 1'b0);
    bus.start_i     = 1'b1;
    bus.dest_addr_i = 3'd1;
    step();
    bus.start_i = 1'b0;
    chk("err_mid_beat", 64'(bus.beat_o), 64'd2);
    chk("err_mid_addr", 64'(bus.wb_addr_o), 64'd6);
    for (int b = 2; b < BEATS; b++) send_beat(b, 1'b0);
    chk_done("err_done");
    chk("err_sticky", 64'(bus.protocol_err_o), 64'd1);
    step();
    chk_idle("err_after", 1'b1);

    // Asynchronous reset between edges after beat 2.
    start_col(3'd7);
    for (int b = 0; b < 3; b++) send_beat(b, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("arst", 1'b0);
    chk("arst_beat", 64'(bus.beat_o), 64'd0);
    chk("arst_addr", 64'(bus.wb_addr_o), 64'd0);
    chk_vec("arst_vec", '0);
    #3;
    rst = 1'b0;
    step();
    start_col(3'd4);
    for (int b = 0; b < BEATS; b++) send_beat(b, 1'b0);
    chk_done("arst_clean");
    chk("arst_clean_err", 64'(bus.protocol_err_o), 64'd0);
    step();
    chk_idle("arst_after", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
